// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM address,
// buffers fetched words in a small FIFO and hands them to decode with a
// valid/ready handshake. A branch redirect flushes the FIFO and restarts
// fetch at the target. Fetch stops once the PC runs past the end of the ROM.
module inst_fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4,
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  // One past the last ROM byte; 33 bits so the comparison never overflows.
  localparam logic [32:0]      ROM_BYTES = 33'd1 << (ADDR_W + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        entry_pc_q   [DEPTH];
  logic [31:0]        entry_inst_q [DEPTH];

  logic               do_push_s;
  logic               do_pop_s;
  logic [31:0]        pc_inc_s;

  // Next-state logic: redirect beats everything, otherwise fetch/pop bookkeeping.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    pc_inc_s  = pc_q + 32'd4;

    if (br_taken) begin
      // Flush: queued entries are wrong-path; the pop of this cycle is dropped.
      state_d  = ST_RUN;
      pc_d     = br_target & 32'hFFFF_FFFC;
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      cnt_d    = CNT_ZERO;
    end else begin
      do_pop_s = (cnt_q != CNT_ZERO) && id_ready;

      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          // A pop this cycle frees a slot, so a full queue can still accept.
          if ((cnt_q != FULL_CNT) || do_pop_s) begin
            do_push_s = 1'b1;
            pc_d      = pc_inc_s;
            if ({1'b0, pc_inc_s} >= ROM_BYTES) begin
              state_d = ST_HALT;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control registers: FSM state, PC, queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Queue storage: capture the PC and the combinational ROM word on a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc_q[i]   <= 32'd0;
        entry_inst_q[i] <= 32'd0;
      end
    end else if (do_push_s) begin
      entry_pc_q[wr_ptr_q]   <= pc_q;
      entry_inst_q[wr_ptr_q] <= rom_inst;
    end
  end

  assign rom_addr = pc_q[ADDR_W+1:2];
  assign halted   = (state_q == ST_HALT);

  // Head-of-queue presentation; all fields read as zero when the queue is empty.
  always_comb begin
    if_valid = 1'b0;
    if_pc    = 32'd0;
    if_inst  = 32'd0;
    if_pc4   = 32'd0;
    if (cnt_q != CNT_ZERO) begin
      if_valid = 1'b1;
      if_pc    = entry_pc_q[rd_ptr_q];
      if_inst  = entry_inst_q[rd_ptr_q];
      if_pc4   = entry_pc_q[rd_ptr_q] + 32'd4;
    end else begin
      if_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios followed by a randomized
// phase, all checked against a queue-based behavioural model of the fetch stage.
module tb_inst_fetch_unit;

  localparam int          ADDR_W    = 6;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_WORDS = 1 << ADDR_W;
  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              br_taken;
  logic [31:0]       br_target;
  logic              id_ready;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic [31:0]       if_pc4;
  logic              halted;

  logic [31:0] rom_mem [0:ROM_WORDS-1];
  assign rom_inst = rom_mem[rom_addr];

  inst_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .br_taken  (br_taken),
    .br_target (br_target),
    .id_ready  (id_ready),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .if_pc4    (if_pc4),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of fetched PCs plus the fetch PC and two flags.
  logic [31:0] q_pc [$];
  logic [31:0] m_pc;
  bit          m_idle;
  bit          m_halt;
  logic [31:0] delivered [$];

  int tests;
  int failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    m_pc   = RESET_PC;
    m_idle = 1'b1;
    m_halt = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit br, input logic [31:0] tgt, input bit rdy);
    if (br) begin
      q_pc.delete();
      m_pc   = {tgt[31:2], 2'b00};
      m_idle = 1'b0;
      m_halt = 1'b0;
    end else begin
      if (rdy && q_pc.size() > 0) void'(q_pc.pop_front());
      if (m_idle) begin
        m_idle = 1'b0;
      end else if (!m_halt && q_pc.size() < DEPTH) begin
        q_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        if (m_pc >= ROM_BYTES) m_halt = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] epc4;
    ev    = (q_pc.size() > 0);
    epc   = ev ? q_pc[0] : 32'd0;
    einst = ev ? rom_mem[epc[ADDR_W+1:2]] : 32'd0;
    epc4  = ev ? epc + 32'd4 : 32'd0;
    check($sformatf("%s.if_valid", ph), {31'd0, if_valid}, {31'd0, ev});
    check($sformatf("%s.if_pc", ph), if_pc, epc);
    check($sformatf("%s.if_inst", ph), if_inst, einst);
    check($sformatf("%s.if_pc4", ph), if_pc4, epc4);
    check($sformatf("%s.halted", ph), {31'd0, halted}, {31'd0, m_halt});
    check($sformatf("%s.rom_addr", ph), 32'(rom_addr), 32'(m_pc[ADDR_W+1:2]));
  endtask

  // Drive inputs, take one clock edge, advance the model, then compare.
  task automatic step(input bit br, input logic [31:0] tgt, input bit rdy, input string ph);
    br_taken  = br;
    br_target = tgt;
    id_ready  = rdy;
    if (!br && rdy && if_valid) delivered.push_back(if_pc);
    @(posedge clk);
    model_edge(br, tgt, rdy);
    #1;
    check_outputs(ph);
  endtask

  // Assert reset between clock edges and check the outputs drop at once.
  task automatic async_reset(input string ph);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(ph);
    check($sformatf("%s.valid0", ph), {31'd0, if_valid}, 32'd0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst       = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'd0;
    id_ready  = 1'b0;
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
    model_reset();

    // Reset state
    #12;
    check_outputs("reset");
    #1;
    rst = 1'b0;

    // 1: steady id_ready, first valid two cycles after release
    step(1'b0, 32'd0, 1'b1, "t1");
    check("t1.first_not_valid", {31'd0, if_valid}, 32'd0);
    step(1'b0, 32'd0, 1'b1, "t1");
    check("t1.first_valid_pc", if_pc, 32'd0);
    check("t1.first_inst", if_inst, rom_mem[0]);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1, "t1");

    // 2: stall after first valid, then drain without loss or duplication
    async_reset("t2rst");
    step(1'b0, 32'd0, 1'b0, "t2");
    step(1'b0, 32'd0, 1'b0, "t2");
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, "t2stall");
    check("t2.rom_addr_hold", 32'(rom_addr), 32'd2);
    check("t2.if_pc_hold", if_pc, 32'd0);
    delivered.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, "t2drain");
    check("t2.count", delivered.size(), 32'd3);
    if (delivered.size() == 3) begin
      check("t2.deliv0", delivered[0], 32'h0);
      check("t2.deliv1", delivered[1], 32'h4);
      check("t2.deliv2", delivered[2], 32'h8);
    end

    // 3: redirect while the queue is full
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, "t3fill");
    step(1'b1, 32'h1C, 1'b1, "t3br");
    check("t3.flush_valid", {31'd0, if_valid}, 32'd0);
    step(1'b0, 32'd0, 1'b1, "t3");
    check("t3.target_pc", if_pc, 32'h1C);
    check("t3.target_pc4", if_pc4, 32'h20);
    step(1'b0, 32'd0, 1'b1, "t3");

    // 4: low target bits are ignored
    step(1'b1, 32'h1F, 1'b1, "t4br");
    check("t4.rom_addr", 32'(rom_addr), 32'd7);
    step(1'b0, 32'd0, 1'b1, "t4");
    check("t4.if_pc", if_pc, 32'h1C);

    // 5: run off the end of the ROM, then restart with a redirect
    step(1'b1, 32'hE0, 1'b1, "t5br");
    delivered.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b1, "t5run");
    check("t5.halted", {31'd0, halted}, 32'd1);
    check("t5.last_pc", delivered.size() > 0 ? delivered[$] : 32'hDEAD_BEEF, 32'hFC);
    step(1'b1, 32'h08, 1'b1, "t5br2");
    check("t5.unhalt", {31'd0, halted}, 32'd0);
    step(1'b0, 32'd0, 1'b1, "t5");
    check("t5.restart_pc", if_pc, 32'h08);

    // Randomized phase
    for (int i = 0; i < 300; i++) begin
      bit          rb;
      bit          rr;
      logic [31:0] rt;
      rb = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 3) != 0);
      rt = $urandom_range(0, ROM_BYTES - 1);
      step(rb, rt, rr, "rand");
    end

    // 6: asynchronous reset with entries queued, then restart at RESET_PC
    step(1'b1, 32'h40, 1'b0, "t6br");
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, "t6fill");
    check("t6.queued", {31'd0, if_valid}, 32'd1);
    async_reset("t6rst");
    check("t6.pc_zero", if_pc, 32'd0);
    check("t6.halted_zero", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, "t6");
    check("t6.restart_pc", if_pc, RESET_PC + 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
